// File: rtl/arb8_pkg.sv
// Shared constants and state encoding for the 8-requester arbiter.
package arb8_pkg;
  localparam int NREQ         = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 15;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
endpackage

// File: rtl/arb8_rot_pick.sv
// Combinational rotating-priority picker: rotate by base, 8-to-3 encode (highest wins), un-rotate.
module arb8_rot_pick
  import arb8_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             mode,
  output logic [IDX_W-1:0] winner,
  output logic             any
);
  logic [IDX_W-1:0] base, pos;
  logic [NREQ-1:0]  rot;

  // Fixed mode is a rotation by zero, so both modes share one encoder.
  assign base = mode ? last_idx : '0;

  always_comb begin
    rot = '0;
    for (int j = 0; j < NREQ; j++) rot[j] = req[IDX_W'(j + int'(base))];
  end

  always_comb begin
    pos = '0;
    for (int j = 0; j < NREQ; j++) if (rot[j]) pos = IDX_W'(j);
  end

  assign winner = pos + base;
  assign any    = |req;
endmodule

// File: rtl/arb8_prio_sched.sv
// 8-requester tenure-holding arbiter, fixed or round-robin priority.
// Define ARB8_HOLD_TIMEOUT_EN to force release after MAX_HOLD cycles when others wait.
module arb8_prio_sched
  import arb8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             mode,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 1..255");
  end

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] last_idx, last_nxt, idx_nxt, winner;
  logic [NREQ-1:0]  grant_nxt;
  logic             valid_nxt, any, timeout;

  arb8_rot_pick u_pick (
    .req     (req),
    .last_idx(last_idx),
    .mode    (mode),
    .winner  (winner),
    .any     (any)
  );

`ifdef ARB8_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  logic [7:0] hold_cnt, hold_inc;

  // Saturates at the limit so a lone holder keeps its grant indefinitely.
  assign hold_inc = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + 8'd1;
  assign timeout  = (hold_inc == HOLD_LIM) && |(req & ~grant);

  always_ff @(posedge clk) begin
    if (!rst_n)              hold_cnt <= '0;
    else if (state == GRANT) hold_cnt <= hold_inc;
    else                     hold_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    valid_nxt = grant_valid;
    last_nxt  = last_idx;
    case (state)
      IDLE: if (any) begin
        grant_nxt = NREQ'(1) << winner;
        idx_nxt   = winner;
        valid_nxt = 1'b1;
        state_nxt = GRANT;
      end
      GRANT: if (!req[grant_idx] || timeout) begin
        grant_nxt = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        last_nxt  = grant_idx;
        state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      last_idx    <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      last_idx    <= last_nxt;
    end
  end

  a_onehot: assert property (@(posedge clk) $onehot0(grant));
  a_valid:  assert property (@(posedge clk) grant_valid == |grant);
  a_idx:    assert property (@(posedge clk) grant_valid |-> grant == (NREQ'(1) << grant_idx));
endmodule

// File: tb/tb_arb8_prio_sched.sv
// Scoreboard bench for arb8_prio_sched: expected grant pushed per driven cycle, checked after the edge.
module tb_arb8_prio_sched;
  import arb8_pkg::*;

`ifdef ARB8_HOLD_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = MAX_HOLD_DEF;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic             mode = 1'b0;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  typedef struct packed {logic v; logic [IDX_W-1:0] idx;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   nchk = 0, nfail = 0, step = 0;

  arb8_prio_sched #(.MAX_HOLD(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus plus the grant expected right after that edge.
  task automatic cyc(input logic r, input logic m, input logic [7:0] q,
                     input logic v, input logic [2:0] i);
    exp_t e;
    @(negedge clk);
    rst_n = r; mode = m; req = q;
    e.v = v; e.idx = i;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      step++;
      chk($sformatf("s%0d_valid", step), 32'(grant_valid), 32'(mon_e.v));
      chk($sformatf("s%0d_idx", step), 32'(grant_idx), 32'(mon_e.v ? mon_e.idx : 3'd0));
      chk($sformatf("s%0d_grant", step), 32'(grant),
          32'(mon_e.v ? (8'd1 << mon_e.idx) : 8'd0));
    end
  end

  logic [2:0] cur;

  initial begin
    // reset with everyone requesting, then first grant on release edge
    cyc(0, 0, 8'hFF, 0, 0);
    cyc(0, 0, 8'hFF, 0, 0);
    cyc(1, 0, 8'hFF, 1, 7);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);

    // fixed priority, release, gap, next winner; others ignored while held
    cyc(1, 0, 8'h24, 1, 5);
    cyc(1, 0, 8'h24, 1, 5);
    cyc(1, 0, 8'h04, 0, 0);
    cyc(1, 0, 8'h04, 0, 0);
    cyc(1, 0, 8'h04, 1, 2);
    cyc(1, 0, 8'h84, 1, 2);
    cyc(1, 0, 8'h80, 0, 0);
    cyc(1, 0, 8'h80, 0, 0);
    cyc(1, 0, 8'h80, 1, 7);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);

    // round robin from reset: 7,6,...,0,7
    cyc(0, 1, 8'h00, 0, 0);
    cyc(1, 1, 8'hFF, 1, 7);
    for (int k = 0; k < 8; k++) begin
      cur = 3'(7 - k);
      cyc(1, 1, 8'hFF, 1, cur);
      cyc(1, 1, 8'hFF & ~(8'd1 << cur), 0, 0);
      cyc(1, 1, 8'hFF, 0, 0);
      cyc(1, 1, 8'hFF, 1, cur - 3'd1);
    end
    cyc(1, 1, 8'h00, 0, 0);
    cyc(1, 1, 8'h00, 0, 0);

    // leave last_idx = 3, then reset mid-grant must clear it
    cyc(1, 0, 8'h08, 1, 3);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h08, 1, 3);
    cyc(1, 0, 8'h08, 1, 3);
    cyc(0, 0, 8'h08, 0, 0);
    cyc(1, 1, 8'h0A, 1, 3);
    cyc(1, 1, 8'h00, 0, 0);
    cyc(1, 1, 8'h00, 0, 0);

    // long idle, then single-cycle grant latency proves IDLE
    for (int k = 0; k < 20; k++) cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h40, 1, 6);
    // release coinciding with new requests: gap first
    cyc(1, 0, 8'h21, 0, 0);
    cyc(1, 0, 8'h21, 0, 0);
    cyc(1, 0, 8'h21, 1, 5);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);

`ifdef ARB8_HOLD_TIMEOUT_EN
    cyc(0, 1, 8'h00, 0, 0);
    cyc(1, 1, 8'h81, 1, 7);
    for (int k = 0; k < 3; k++) cyc(1, 1, 8'h81, 1, 7);
    cyc(1, 1, 8'h81, 0, 0);
    cyc(1, 1, 8'h81, 0, 0);
    cyc(1, 1, 8'h81, 1, 0);
    cyc(1, 1, 8'h00, 0, 0);
    cyc(1, 1, 8'h00, 0, 0);
    // lone holder saturates; a newcomer forces immediate release
    for (int k = 0; k < 20; k++) cyc(1, 1, 8'h80, 1, 7);
    cyc(1, 1, 8'h81, 0, 0);
    cyc(1, 1, 8'h00, 0, 0);
`endif

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
